// File: rtl/game_counter_gen2_pkg.sv
// Shared types for the game counter: ctrl bus decode, result encoding, FSM states.
package game_counter_pkg;

    typedef enum logic [1:0] {
        UP_ONE    = 2'b00,
        UP_STEP   = 2'b01,
        DOWN_ONE  = 2'b10,
        DOWN_STEP = 2'b11
    } ctrl_e;

    typedef enum logic [1:0] {
        WHO_NONE   = 2'b00,
        WHO_LOSER  = 2'b01,
        WHO_WINNER = 2'b10
    } who_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        OVER = 2'b10
    } state_e;

endpackage

// File: rtl/game_counter_gen2_if.sv
// Control/status bundle between the counter testbench and the game counter.
interface game_counter_gen2_if #(
    parameter int COUNTER_SIZE = 4,
    parameter int TALLY_W      = 4
);
    logic                    INIT;
    logic                    en;
    logic [1:0]              ctrl;
    logic [COUNTER_SIZE-1:0] loadValue;
    logic [COUNTER_SIZE-1:0] count;
    logic                    LOSER;
    logic                    WINNER;
    logic                    GAMEOVER;
    logic [1:0]              WHO;
    logic [TALLY_W-1:0]      loser_count;
    logic [TALLY_W-1:0]      win_count;

    modport master (
        output INIT, en, ctrl, loadValue,
        input  count, LOSER, WINNER, GAMEOVER, WHO, loser_count, win_count
    );

    modport slave (
        input  INIT, en, ctrl, loadValue,
        output count, LOSER, WINNER, GAMEOVER, WHO, loser_count, win_count
    );
endinterface

// File: rtl/game_counter_gen2_tally.sv
// Saturating-free tally register with a look-ahead flag for reaching LIMIT.
module game_tally #(
    parameter int WIDTH = 4,
    parameter int LIMIT = 15
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             hit_limit
);
    localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

    // Flag the increment that will make the tally equal LIMIT.
    always_comb begin
        hit_limit = inc && ((count + WIDTH'(1)) == LIMIT_V);
    end

    // Tally register: clear on INIT, step on each detected event.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + WIDTH'(1);
        end
    end
endmodule

// File: rtl/game_counter_gen2.sv
// Multi-mode game counter: up/down by 1 or STEP2, win/lose tallies, game ends
// when either tally reaches WIN_LIMIT. Define COUNTER_SAT_EN to clamp the
// count at 0/max instead of wrapping.
module game_counter_gen2
    import game_counter_pkg::*;
#(
    parameter int COUNTER_SIZE = 4,
    parameter int STEP2        = 2,
    parameter int WIN_LIMIT    = 15
) (
    input logic                clk,
    input logic                rst_l,
    game_counter_gen2_if.slave bus
);
    localparam int TALLY_W = $clog2(WIN_LIMIT + 1);
    localparam logic [COUNTER_SIZE-1:0] CNT_MAX  = '1;
    localparam logic [COUNTER_SIZE:0]   STEP_BIG = (COUNTER_SIZE + 1)'(STEP2);
    localparam logic [COUNTER_SIZE:0]   ONE_BIG  = (COUNTER_SIZE + 1)'(1);

    state_e                  state_q, state_d;
    logic [COUNTER_SIZE-1:0] count_q, count_d;
    logic                    loser_q, loser_d;
    logic                    winner_q, winner_d;
    logic                    go_q, go_d;
    who_e                    who_q, who_d;

    ctrl_e                   op;
    logic                    step_up;
    logic [COUNTER_SIZE:0]   step;
    logic [COUNTER_SIZE:0]   sum_up;
    logic [COUNTER_SIZE:0]   diff_dn;
    logic [COUNTER_SIZE-1:0] stepped;

    logic                    counting;
    logic                    lose_inc, win_inc;
    logic                    lose_hit, win_hit;
    logic                    tally_clr;

    // Next count value; one extra bit exposes carry/borrow for the clamp.
    always_comb begin
        op      = ctrl_e'(bus.ctrl);
        step_up = (op == UP_ONE) || (op == UP_STEP);
        step    = ((op == UP_STEP) || (op == DOWN_STEP)) ? STEP_BIG : ONE_BIG;
        sum_up  = {1'b0, count_q} + step;
        diff_dn = {1'b0, count_q} - step;
`ifdef COUNTER_SAT_EN
        if (step_up) begin
            stepped = sum_up[COUNTER_SIZE] ? CNT_MAX : sum_up[COUNTER_SIZE-1:0];
        end else begin
            stepped = diff_dn[COUNTER_SIZE] ? '0 : diff_dn[COUNTER_SIZE-1:0];
        end
`else
        stepped = step_up ? sum_up[COUNTER_SIZE-1:0] : diff_dn[COUNTER_SIZE-1:0];
`endif
    end

    // Edge detection on the pre-update count; kept apart from the FSM so the
    // tally look-ahead does not feed back into the block that drives it.
    always_comb begin
        counting  = !bus.INIT && (state_q == RUN) && bus.en;
        lose_inc  = counting && (count_q == '0);
        win_inc   = counting && (count_q == CNT_MAX);
        tally_clr = bus.INIT;
    end

    game_tally #(.WIDTH(TALLY_W), .LIMIT(WIN_LIMIT)) u_lose_tally (
        .clk       (clk),
        .rst_l     (rst_l),
        .clr       (tally_clr),
        .inc       (lose_inc),
        .count     (bus.loser_count),
        .hit_limit (lose_hit)
    );

    game_tally #(.WIDTH(TALLY_W), .LIMIT(WIN_LIMIT)) u_win_tally (
        .clk       (clk),
        .rst_l     (rst_l),
        .clr       (tally_clr),
        .inc       (win_inc),
        .count     (bus.win_count),
        .hit_limit (win_hit)
    );

    // FSM next state and next registered outputs; INIT overrides everything.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        loser_d  = 1'b0;
        winner_d = 1'b0;
        go_d     = go_q;
        who_d    = who_q;
        if (bus.INIT) begin
            state_d = RUN;
            count_d = bus.loadValue;
            go_d    = 1'b0;
            who_d   = WHO_NONE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                RUN: begin
                    if (bus.en) begin
                        count_d  = stepped;
                        loser_d  = lose_inc;
                        winner_d = win_inc;
                        if (lose_hit) begin
                            go_d    = 1'b1;
                            who_d   = WHO_LOSER;
                            state_d = OVER;
                        end else if (win_hit) begin
                            go_d    = 1'b1;
                            who_d   = WHO_WINNER;
                            state_d = OVER;
                        end
                    end
                end
                OVER: begin
                    state_d = OVER;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q  <= IDLE;
            count_q  <= '0;
            loser_q  <= 1'b0;
            winner_q <= 1'b0;
            go_q     <= 1'b0;
            who_q    <= WHO_NONE;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            loser_q  <= loser_d;
            winner_q <= winner_d;
            go_q     <= go_d;
            who_q    <= who_d;
        end
    end

    // Drive the registered values onto the bus.
    always_comb begin
        bus.count    = count_q;
        bus.LOSER    = loser_q;
        bus.WINNER   = winner_q;
        bus.GAMEOVER = go_q;
        bus.WHO      = who_q;
    end
endmodule

// File: tb/tb_game_counter_gen2.sv
// Bench for game_counter_gen2: two instances (WIN_LIMIT 15 and 2) share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_game_counter_gen2;

    localparam int MAXV    = 15;
    localparam int ST_IDLE = 0;
    localparam int ST_RUN  = 1;
    localparam int ST_OVER = 2;

    logic clk;
    logic rst_l;

    game_counter_gen2_if #(.COUNTER_SIZE(4), .TALLY_W(4)) bus_a ();
    game_counter_gen2_if #(.COUNTER_SIZE(4), .TALLY_W(2)) bus_b ();

    game_counter_gen2 #(.COUNTER_SIZE(4), .STEP2(2), .WIN_LIMIT(15)) dut_a (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus_a)
    );

    game_counter_gen2 #(.COUNTER_SIZE(4), .STEP2(2), .WIN_LIMIT(2)) dut_b (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    int lim   [2] = '{15, 2};
    int m_st  [2];
    int m_cnt [2];
    int m_lt  [2];
    int m_wt  [2];
    int m_los [2];
    int m_win [2];
    int m_go  [2];
    int m_who [2];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = ST_IDLE; m_cnt[i] = 0; m_lt[i] = 0; m_wt[i] = 0;
            m_los[i] = 0; m_win[i] = 0; m_go[i] = 0; m_who[i] = 0;
        end
    endtask

    // One rising edge of the game rules, using the inputs currently driven.
    task automatic model_edge(input int i);
        int pre, d, n;
        if (bus_a.INIT === 1'b1) begin
            m_cnt[i] = int'(bus_a.loadValue);
            m_lt[i] = 0; m_wt[i] = 0; m_los[i] = 0; m_win[i] = 0;
            m_go[i] = 0; m_who[i] = 0; m_st[i] = ST_RUN;
        end else if (m_st[i] == ST_RUN && bus_a.en === 1'b1) begin
            pre = m_cnt[i];
            d   = bus_a.ctrl[0] ? 2 : 1;
            n   = bus_a.ctrl[1] ? pre - d : pre + d;
`ifdef COUNTER_SAT_EN
            if (n > MAXV) n = MAXV;
            if (n < 0) n = 0;
`else
            n = (n + MAXV + 1) % (MAXV + 1);
`endif
            m_cnt[i] = n;
            m_los[i] = (pre == 0) ? 1 : 0;
            m_win[i] = (pre == MAXV) ? 1 : 0;
            if (pre == 0) begin
                m_lt[i]++;
                if (m_lt[i] == lim[i]) begin
                    m_go[i] = 1; m_who[i] = 1; m_st[i] = ST_OVER;
                end
            end
            if (pre == MAXV) begin
                m_wt[i]++;
                if (m_wt[i] == lim[i]) begin
                    m_go[i] = 1; m_who[i] = 2; m_st[i] = ST_OVER;
                end
            end
        end else begin
            m_los[i] = 0;
            m_win[i] = 0;
        end
    endtask

    task automatic compare_all();
        check_eq("a.count",  int'(bus_a.count),       m_cnt[0]);
        check_eq("a.LOSER",  int'(bus_a.LOSER),       m_los[0]);
        check_eq("a.WINNER", int'(bus_a.WINNER),      m_win[0]);
        check_eq("a.GO",     int'(bus_a.GAMEOVER),    m_go[0]);
        check_eq("a.WHO",    int'(bus_a.WHO),         m_who[0]);
        check_eq("a.lose_t", int'(bus_a.loser_count), m_lt[0]);
        check_eq("a.win_t",  int'(bus_a.win_count),   m_wt[0]);
        check_eq("b.count",  int'(bus_b.count),       m_cnt[1]);
        check_eq("b.LOSER",  int'(bus_b.LOSER),       m_los[1]);
        check_eq("b.WINNER", int'(bus_b.WINNER),      m_win[1]);
        check_eq("b.GO",     int'(bus_b.GAMEOVER),    m_go[1]);
        check_eq("b.WHO",    int'(bus_b.WHO),         m_who[1]);
        check_eq("b.lose_t", int'(bus_b.loser_count), m_lt[1]);
        check_eq("b.win_t",  int'(bus_b.win_count),   m_wt[1]);
    endtask

    task automatic drive(input logic init, input logic en, input logic [1:0] ctrl,
                         input logic [3:0] load);
        bus_a.INIT = init; bus_a.en = en; bus_a.ctrl = ctrl; bus_a.loadValue = load;
        bus_b.INIT = init; bus_b.en = en; bus_b.ctrl = ctrl; bus_b.loadValue = load;
    endtask

    // Advance one edge, update the model, sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        compare_all();
    endtask

    // Asynchronous reset pulse placed between two rising edges.
    task automatic mid_cycle_reset();
        #2;
        rst_l = 1'b0;
        model_reset();
        #1;
        compare_all();
        #1;
        rst_l = 1'b1;
    endtask

    int exp_v;

    initial begin
        rst_l = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 4'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst_l = 1'b1;

        // Idle after reset ignores en.
        drive(1'b0, 1'b1, 2'b00, 4'd5);
        repeat (3) tick();

        // Count to max, then WINNER, then LOSER on wrap.
        drive(1'b1, 1'b1, 2'b00, 4'd14);
        tick();
        drive(1'b0, 1'b1, 2'b00, 4'd14);
        tick();
        check_eq("t1.count15", int'(bus_a.count), 15);
        tick();
        check_eq("t1.winner", int'(bus_a.WINNER), 1);
        check_eq("t1.win_t",  int'(bus_a.win_count), 1);
        tick();

        // Down by STEP2 from 1: wraps to 15, or clamps to 0.
        drive(1'b1, 1'b1, 2'b11, 4'd1);
        tick();
        drive(1'b0, 1'b1, 2'b11, 4'd1);
        tick();
`ifdef COUNTER_SAT_EN
        exp_v = 0;
`else
        exp_v = 15;
`endif
        check_eq("t2.count", int'(bus_a.count), exp_v);
        repeat (3) tick();

        // Limit 2 instance: second lose ends the game.
        drive(1'b1, 1'b1, 2'b00, 4'd0);
        tick();
        drive(1'b0, 1'b1, 2'b00, 4'd0);
        repeat (17) tick();
`ifndef COUNTER_SAT_EN
        check_eq("t3.go",    int'(bus_b.GAMEOVER), 1);
        check_eq("t3.who",   int'(bus_b.WHO), 1);
        check_eq("t3.count", int'(bus_b.count), 1);
`endif

        // OVER is frozen; INIT restarts.
        repeat (5) tick();
        drive(1'b1, 1'b1, 2'b00, 4'd7);
        tick();
        check_eq("t4.count", int'(bus_b.count), 7);
        check_eq("t4.go",    int'(bus_b.GAMEOVER), 0);

        // Async reset mid-cycle while running at 9; stays idle until INIT.
        drive(1'b1, 1'b0, 2'b00, 4'd9);
        tick();
        drive(1'b0, 1'b0, 2'b00, 4'd9);
        mid_cycle_reset();
        drive(1'b0, 1'b1, 2'b01, 4'd9);
        repeat (4) tick();

        // INIT overrides en; en=0 holds.
        drive(1'b1, 1'b1, 2'b01, 4'd3);
        tick();
        check_eq("t6.count", int'(bus_a.count), 3);
        drive(1'b0, 1'b0, 2'b01, 4'd3);
        repeat (4) tick();
        check_eq("t6.hold", int'(bus_a.count), 3);

        // Randomised run.
        for (int k = 0; k < 1500; k++) begin
            drive(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0,
                  2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)));
            if ($urandom_range(0, 299) == 0) begin
                mid_cycle_reset();
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
